logic_gate_checker: RTL and testbench

Sequential self-test stage wrapped around the two-input logic gate block. It drives the gate block's `a`/`b` inputs through all four input patterns and holds each pattern for a settle interval. It then samples the six gate outputs, compares them against the golden truth table, and reports a per-gate fail mask, a mismatch count and a pass flag. It sits directly upstream (stimulus) and downstream (response capture) of the gate block in the board-level test top.

---
 rtl/logic_gate_pkg.sv | 29 ++
 rtl/gate_expect.sv | 14 +
 rtl/logic_gate_checker.sv | 146 ++++++++++++++
 tb/tb_logic_gate_checker.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared types and golden truth table for the two-input logic gate self-test.
// Gate output bit order is {XNOR, NAND, NOR, XOR, AND, OR}.
package logic_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } lgc_state_t;

  localparam int NUM_GATES = 6;

  localparam int G_OR   = 0;
  localparam int G_AND  = 1;
  localparam int G_XOR  = 2;
  localparam int G_NOR  = 3;
  localparam int G_NAND = 4;
  localparam int G_XNOR = 5;

  // Indexed by {a,b}
  localparam logic [NUM_GATES-1:0] GATE_EXP [0:3] = '{
    6'b111000,
    6'b010101,
    6'b010101,
    6'b100011
  };

endpackage

// File: rtl/gate_expect.sv
// Combinational golden model: expected six gate outputs for a given (a,b) pattern.
module gate_expect
  import logic_gate_pkg::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_GATES-1:0] exp_o
);

  always_comb begin
    exp_o = GATE_EXP[{a_i, b_i}];
  end

endmodule

// File: rtl/logic_gate_checker.sv
// Self-test sequencer for the logic gate block: walks a/b through all four
// patterns, samples the gate outputs after a settle interval and scores them.
module logic_gate_checker
  import logic_gate_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  input  logic [5:0] y_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [5:0] fail_mask
);

  localparam logic [7:0] HC_LAST = 8'(HOLD_CYCLES - 1);

  lgc_state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] hc_q, hc_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic [5:0] fail_mask_q, fail_mask_d;

  logic [NUM_GATES-1:0] exp_vec;
  logic [NUM_GATES-1:0] diff;
  logic [NUM_GATES-1:0] mask_upd;
  logic [1:0]           idx_nxt;

  gate_expect u_gate_expect (
    .a_i   (idx_q[1]),
    .b_i   (idx_q[0]),
    .exp_o (exp_vec)
  );

  assign diff     = y_i ^ exp_vec;
  assign mask_upd = fail_mask_q | diff;
  assign idx_nxt  = idx_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hc_d        = hc_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fail_mask_d = fail_mask_q;

    case (state_q)
      ST_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          err_cnt_d   = 3'd0;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          idx_d       = 2'd0;
          hc_d        = 8'd0;
          busy_d      = 1'b1;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        hc_d = hc_q + 8'd1;
        if (hc_q == HC_LAST) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        fail_mask_d = mask_upd;
        if (|diff) begin
          err_cnt_d = err_cnt_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          // Pass must reflect this final sample, so use the updated mask.
          pass_d  = (mask_upd == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_nxt;
          hc_d    = 8'd0;
          a_d     = idx_nxt[1];
          b_d     = idx_nxt[0];
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      hc_q        <= 8'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= 3'd0;
      fail_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hc_q        <= hc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_logic_gate_checker.sv
// Bench for logic_gate_checker: two instances (HOLD_CYCLES 4 and 1) driven by a
// behavioural gate block with injectable stuck-at-0 and inversion faults.
module tb_logic_gate_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start4, a4, b4, busy4, done4, pass4;
  logic [5:0] y4, mask4, am4, xm4;
  logic [2:0] err4;
  logic       start1, a1, b1, busy1, done1, pass1;
  logic [5:0] y1, mask1, am1, xm1;
  logic [2:0] err1;

  int n_checks = 0;
  int n_fail   = 0;

  // Ideal gate block: {XNOR, NAND, NOR, XOR, AND, OR}
  function automatic logic [5:0] gate_truth(input logic a, input logic b);
    return {~(a ^ b), ~(a & b), ~(a | b), a ^ b, a & b, a | b};
  endfunction

  assign y4 = (gate_truth(a4, b4) & am4) ^ xm4;
  assign y1 = (gate_truth(a1, b1) & am1) ^ xm1;

  logic_gate_checker #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_o(a4), .b_o(b4), .y_i(y4),
    .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4), .fail_mask(mask4)
  );

  logic_gate_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_o(a1), .b_o(b1), .y_i(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_mask(mask1)
  );

  function automatic logic get_busy(input bit w); return w ? busy1 : busy4; endfunction
  function automatic logic get_done(input bit w); return w ? done1 : done4; endfunction
  function automatic logic get_pass(input bit w); return w ? pass1 : pass4; endfunction
  function automatic logic get_a(input bit w);    return w ? a1 : a4;       endfunction
  function automatic logic get_b(input bit w);    return w ? b1 : b4;       endfunction
  function automatic logic [2:0] get_err(input bit w);  return w ? err1 : err4;   endfunction
  function automatic logic [5:0] get_mask(input bit w); return w ? mask1 : mask4; endfunction

  task automatic drive_start(input bit w, input logic v);
    if (w) start1 = v; else start4 = v;
  endtask

  task automatic set_faults(input bit w, input logic [5:0] am, input logic [5:0] xm);
    if (w) begin am1 = am; xm1 = xm; end
    else   begin am4 = am; xm4 = xm; end
  endtask

  // Reference scoring: what a run over all four patterns should report.
  task automatic ref_model(input logic [5:0] am, input logic [5:0] xm,
                           output logic [5:0] em, output logic [2:0] ec, output logic ep);
    logic [5:0] t, d;
    int cnt;
    em = '0;
    cnt = 0;
    for (int p = 0; p < 4; p++) begin
      t = gate_truth(p[1], p[0]);
      d = ((t & am) ^ xm) ^ t;
      em |= d;
      if (d != 0) cnt++;
    end
    ec = 3'(cnt);
    ep = (em == 0);
  endtask

  task automatic do_run(input bit w, input logic [5:0] am, input logic [5:0] xm,
                        input bit rnd, input string tag);
    int h, last, done_k, done_n, busy_n, busy_bad, pat_err, pidx;
    logic [5:0] em, rm;
    logic [2:0] ec, re;
    logic ep, rp, ea, eb;
    h = w ? 1 : 4;
    last = 4 * (h + 1);
    done_k = -1; done_n = 0; busy_n = 0; busy_bad = 0; pat_err = 0;
    rm = 'x; re = 'x; rp = 1'bx;
    set_faults(w, am, xm);
    ref_model(am, xm, em, ec, ep);
    drive_start(w, 1'b1);
    @(posedge clk); #1;
    drive_start(w, 1'b0);
    for (int k = 1; k <= last + 3; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (get_busy(w)) busy_n++;
      if (get_busy(w) !== (k <= last)) busy_bad++;
      if (get_done(w) === 1'b1) begin
        done_n++; done_k = k;
        rp = get_pass(w); re = get_err(w); rm = get_mask(w);
      end
      if (k <= last) begin
        pidx = (k - 1) / (h + 1);
        ea = pidx[1]; eb = pidx[0];
      end else begin
        ea = 1'b0; eb = 1'b0;
      end
      if (get_a(w) !== ea || get_b(w) !== eb) pat_err++;
      if (rnd && k < last) drive_start(w, 1'($urandom_range(0, 1)));
      else drive_start(w, 1'b0);
    end
    n_checks++;
    if (done_k != last + 1) begin n_fail++; $display("FAIL %s done_cycle got %0d want %0d", tag, done_k, last + 1); end
    n_checks++;
    if (done_n != 1) begin n_fail++; $display("FAIL %s done_pulses got %0d want 1", tag, done_n); end
    n_checks++;
    if (busy_n != last || busy_bad != 0) begin n_fail++; $display("FAIL %s busy_cycles got %0d (bad %0d) want %0d", tag, busy_n, busy_bad, last); end
    n_checks++;
    if (pat_err != 0) begin n_fail++; $display("FAIL %s ab_pattern got %0d bad cycles want 0", tag, pat_err); end
    n_checks++;
    if (rp !== ep) begin n_fail++; $display("FAIL %s pass got %b want %b", tag, rp, ep); end
    n_checks++;
    if (re !== ec) begin n_fail++; $display("FAIL %s err_cnt got %0d want %0d", tag, re, ec); end
    n_checks++;
    if (rm !== em) begin n_fail++; $display("FAIL %s fail_mask got %b want %b", tag, rm, em); end
    n_checks++;
    if ({get_pass(w), get_err(w), get_mask(w)} !== {ep, ec, em}) begin
      n_fail++;
      $display("FAIL %s results_held got %b/%0d/%b want %b/%0d/%b", tag,
               get_pass(w), get_err(w), get_mask(w), ep, ec, em);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({a4, b4, busy4, done4, pass4, err4, mask4} !== 14'd0) begin
      n_fail++; $display("FAIL reset_h4 outputs got %b want 0", {a4, b4, busy4, done4, pass4, err4, mask4});
    end
    n_checks++;
    if ({a1, b1, busy1, done1, pass1, err1, mask1} !== 14'd0) begin
      n_fail++; $display("FAIL reset_h1 outputs got %b want 0", {a1, b1, busy1, done1, pass1, err1, mask1});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean;
    do_run(1'b0, 6'h3F, 6'h00, 1'b0, "clean_h4");
  endtask

  task automatic test_xor_stuck;
    do_run(1'b0, 6'b111011, 6'h00, 1'b0, "xor_stuck0");
    n_checks++;
    if (mask4 !== 6'b000100 || err4 !== 3'd2) begin
      n_fail++; $display("FAIL xor_stuck0_direct got %b/%0d want 000100/2", mask4, err4);
    end
  endtask

  task automatic test_invert;
    do_run(1'b0, 6'h3F, 6'h3F, 1'b0, "invert_all");
    n_checks++;
    if (mask4 !== 6'b111111 || err4 !== 3'd4 || pass4 !== 1'b0) begin
      n_fail++; $display("FAIL invert_direct got %b/%0d/%b want 111111/4/0", mask4, err4, pass4);
    end
  endtask

  task automatic test_random;
    logic [5:0] am, xm;
    for (int i = 0; i < 6; i++) begin
      am = 6'h3F; xm = 6'h00;
      if ($urandom_range(0, 1) == 1) am = 6'h3F & ~(6'd1 << $urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) xm = 6'($urandom_range(0, 63));
      do_run(1'(i % 2), am, xm, 1'b0, "random");
    end
  endtask

  task automatic test_reset_midrun;
    set_faults(1'b0, 6'h3F, 6'h3F);
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 2; k <= 9; k++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({a4, b4, busy4, done4, pass4, err4, mask4} !== 14'd0) begin
      n_fail++; $display("FAIL reset_midrun outputs got %b want 0", {a4, b4, busy4, done4, pass4, err4, mask4});
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_midrun_idle busy got %b want 0", busy4); end
    do_run(1'b0, 6'h3F, 6'h00, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    int bad, dn;
    bad = 0; dn = 0;
    set_faults(1'b1, 6'h3F, 6'h00);
    start1 = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (done1 !== (k % 10 == 9)) bad++;
      if (done1 === 1'b1) begin
        dn++;
        if (pass1 !== 1'b1 || err1 !== 3'd0) bad++;
      end
    end
    start1 = 1'b0;
    n_checks++;
    if (dn != 5 || bad != 0) begin n_fail++; $display("FAIL back_to_back got %0d dones, %0d bad cycles want 5, 0", dn, bad); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL back_to_back_stop busy got %b want 0", busy1); end
  endtask

  task automatic test_start_during_busy;
    do_run(1'b0, 6'b111011, 6'h00, 1'b1, "start_noise_h4");
    do_run(1'b1, 6'h3F, 6'h00, 1'b1, "start_noise_h1");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    start4 = 1'b0; start1 = 1'b0;
    am4 = 6'h3F; xm4 = 6'h00; am1 = 6'h3F; xm1 = 6'h00;
    rst = 1'b1;
    test_reset();
    test_clean();
    test_xor_stuck();
    test_invert();
    test_reset_midrun();
    test_back_to_back();
    test_start_during_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
